// File: rtl/serial5_rx.sv
// Serial frame receiver: start bit, 5 data bits LSB first, optional parity, stop bit.
// Bits are taken only on BIT_EN strobes; good words are held on Dout for the next stage.
module serial5_rx #(
  parameter int PARITY_EN = 1,
  parameter int PAR_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SIN,
  input  logic       BIT_EN,
  output logic [4:0] Dout,
  output logic       VALID,
  output logic       PERR,
  output logic       FERR,
  output logic       BUSY
);

  localparam logic L_ODD = (PAR_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_shift, w_shift_nxt;
  logic [4:0] r_dout, w_dout_nxt;
  logic       r_pflag, w_pflag_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_perr, w_perr_nxt;
  logic       r_ferr, w_ferr_nxt;
  logic       r_busy;

  // Valid/ready is not used here: BIT_EN is a qualifier only, SIN is consumed
  // exactly on cycles where BIT_EN=1 and ignored otherwise; the pulses have no back-pressure.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_pflag_nxt = r_pflag;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    if (BIT_EN) begin
      case (r_state)
        S_IDLE: begin
          if (!SIN) begin
            w_cnt_nxt   = 3'd0;
            w_pflag_nxt = 1'b0;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_shift_nxt = {SIN, r_shift[4:1]};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd4) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          w_pflag_nxt = (^r_shift) ^ SIN ^ L_ODD;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          // A framing error wins over a parity error: only FERR is reported.
          if (SIN) begin
            if (!r_pflag) begin
              w_dout_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_perr_nxt = 1'b1;
            end
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
        S_BREAK: begin
          if (SIN) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 5'd0;
      r_dout  <= 5'd0;
      r_pflag <= 1'b0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_pflag <= w_pflag_nxt;
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign Dout  = r_dout;
  assign VALID = r_valid;
  assign PERR  = r_perr;
  assign FERR  = r_ferr;
  assign BUSY  = r_busy;

endmodule

// File: tb/tb_serial5_rx.sv
// Bench for serial5_rx: frame table plus hand-written reset, break, back-to-back
// and sparse-strobe sequences, with a queue of expected words checked on VALID.
module tb_serial5_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SIN = 1'b1;
  logic       BIT_EN = 1'b0;

  logic [4:0] dout1, dout0, dout_o;
  logic       valid1, perr1, ferr1, busy1;
  logic       valid0, perr0, ferr0, busy0;
  logic       valid_o, perr_o, ferr_o, busy_o;

  serial5_rx #(.PARITY_EN(1), .PAR_ODD(0)) u_dut1 (
    .CLK(CLK), .RST(RST), .SIN(SIN), .BIT_EN(BIT_EN),
    .Dout(dout1), .VALID(valid1), .PERR(perr1), .FERR(ferr1), .BUSY(busy1)
  );
  serial5_rx #(.PARITY_EN(0), .PAR_ODD(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .SIN(SIN), .BIT_EN(BIT_EN),
    .Dout(dout0), .VALID(valid0), .PERR(perr0), .FERR(ferr0), .BUSY(busy0)
  );
  serial5_rx #(.PARITY_EN(1), .PAR_ODD(1)) u_dut_odd (
    .CLK(CLK), .RST(RST), .SIN(SIN), .BIT_EN(BIT_EN),
    .Dout(dout_o), .VALID(valid_o), .PERR(perr_o), .FERR(ferr_o), .BUSY(busy_o)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream 5-bit register fed by Dout.
  logic [4:0] ds_reg;
  always @(posedge CLK or posedge RST) begin
    if (RST) ds_reg <= 5'd0;
    else     ds_reg <= dout1;
  end

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Scoreboard / monitor
  logic [4:0] exp_q1[$];
  logic [4:0] exp_q0[$];
  logic [4:0] last_exp1;
  logic       mon1_en = 1'b0;
  logic       mon0_en = 1'b0;
  logic       chk_ds = 1'b0;
  logic       prev_valid1 = 1'b0;
  int v1 = 0, p1 = 0, f1 = 0;
  int vo = 0, po = 0, fo = 0;
  int v0 = 0, p0 = 0, f0 = 0;
  int last_v_cyc = 0, prev_v_cyc = 0;

  always @(negedge CLK) begin
    if (chk_ds) begin
      check("ds_reg", {27'd0, ds_reg}, {27'd0, last_exp1});
      chk_ds = 1'b0;
    end
    if (mon1_en) begin
      check("excl1", {31'd0, (valid1 & perr1) | (valid1 & ferr1) | (perr1 & ferr1)}, 32'd0);
      if (valid1) begin
        check("valid1_width", {31'd0, prev_valid1}, 32'd0);
        v1++;
        prev_v_cyc = last_v_cyc;
        last_v_cyc = cyc;
        if (exp_q1.size() == 0) begin
          check("valid1_unexpected", 32'd1, 32'd0);
        end else begin
          last_exp1 = exp_q1.pop_front();
          check("dout1", {27'd0, dout1}, {27'd0, last_exp1});
          chk_ds = 1'b1;
        end
      end
      if (perr1) p1++;
      if (ferr1) f1++;
      if (valid_o) vo++;
      if (perr_o) po++;
      if (ferr_o) fo++;
    end
    prev_valid1 = valid1;
    if (mon0_en) begin
      check("excl0", {31'd0, (valid0 & perr0) | (valid0 & ferr0) | (perr0 & ferr0)}, 32'd0);
      if (valid0) begin
        v0++;
        if (exp_q0.size() == 0) check("valid0_unexpected", 32'd1, 32'd0);
        else check("dout0", {27'd0, dout0}, {27'd0, exp_q0.pop_front()});
      end
      if (perr0) p0++;
      if (ferr0) f0++;
    end
  end

  // Drivers
  task automatic put_bit(input logic b, input int gap);
    SIN = b;
    BIT_EN = 1'b1;
    @(negedge CLK);
    BIT_EN = 1'b0;
    for (int i = 0; i < gap; i++) begin
      SIN = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [4:0] d, input logic has_par, input logic par,
                            input logic stop, input int gap);
    put_bit(1'b0, gap);
    for (int i = 0; i < 5; i++) put_bit(d[i], gap);
    if (has_par) put_bit(par, gap);
    put_bit(stop, gap);
  endtask

  typedef struct {
    logic [4:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic       e_valid;
    logic       e_perr;
    logic       e_ferr;
    logic [4:0] e_dout;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv, sp, sf, svo, spo, sfo;
    tbl[0] = '{5'b10110, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 5'b10110};
    tbl[1] = '{5'b10110, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 5'b10110};
    tbl[2] = '{5'b00001, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 5'b00001};
    tbl[3] = '{5'b00000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[4] = '{5'b11111, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 5'b11111};
    tbl[5] = '{5'b11111, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 5'b11111};
    tbl[6] = '{5'b01010, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 5'b01010};
    tbl[7] = '{5'b01010, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 5'b01010};
    tbl[8] = '{5'b10110, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 5'b01010};
    tbl[9] = '{5'b11001, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 5'b11001};

    // Reset values
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_dout", {27'd0, dout1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_pulses", {29'd0, valid1, perr1, ferr1}, 32'd0);
    mon1_en = 1'b1;

    // Good frame, then async reset in the middle of the next one
    exp_q1.push_back(5'b10110);
    send_frame(5'b10110, 1'b1, 1'b1, 1'b1, 0);
    put_bit(1'b1, 0);
    @(negedge CLK);
    sv = v1; sp = p1; sf = f1;
    put_bit(1'b0, 0);
    put_bit(1'b1, 0);
    put_bit(1'b0, 0);
    check("mid_busy", {31'd0, busy1}, 32'd1);
    check("mid_dout", {27'd0, dout1}, {27'd0, 5'b10110});
    #2 RST = 1'b1;
    #1;
    check("async_dout", {27'd0, dout1}, 32'd0);
    check("async_busy", {31'd0, busy1}, 32'd0);
    check("async_pulses", {29'd0, valid1, perr1, ferr1}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q1.push_back(5'b00001);
    send_frame(5'b00001, 1'b1, 1'b1, 1'b1, 0);
    put_bit(1'b1, 0);
    @(negedge CLK);
    check("after_rst_valid", 32'(v1 - sv), 32'd1);
    check("after_rst_errs", 32'(p1 - sp + f1 - sf), 32'd0);

    // Frame table
    for (int i = 0; i < 10; i++) begin
      sv = v1; sp = p1; sf = f1; svo = vo; spo = po; sfo = fo;
      if (tbl[i].e_valid) exp_q1.push_back(tbl[i].e_dout);
      send_frame(tbl[i].data, 1'b1, tbl[i].par, tbl[i].stop, tbl[i].gap);
      put_bit(1'b1, 0);
      @(negedge CLK);
      check($sformatf("tbl%0d_valid", i), 32'(v1 - sv), {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_perr", i), 32'(p1 - sp), {31'd0, tbl[i].e_perr});
      check($sformatf("tbl%0d_ferr", i), 32'(f1 - sf), {31'd0, tbl[i].e_ferr});
      check($sformatf("tbl%0d_dout", i), {27'd0, dout1}, {27'd0, tbl[i].e_dout});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy1}, 32'd0);
      check($sformatf("tbl%0d_odd_valid", i), 32'(vo - svo), {31'd0, tbl[i].stop & tbl[i].e_perr});
      check($sformatf("tbl%0d_odd_perr", i), 32'(po - spo), {31'd0, tbl[i].stop & tbl[i].e_valid});
      check($sformatf("tbl%0d_odd_ferr", i), 32'(fo - sfo), {31'd0, tbl[i].e_ferr});
    end

    // Framing error followed by a held-low line
    sv = v1; sf = f1;
    send_frame(5'b11111, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      put_bit(1'b0, 0);
      check("break_busy", {31'd0, busy1}, 32'd1);
    end
    check("break_ferr", 32'(f1 - sf), 32'd1);
    check("break_dout", {27'd0, dout1}, {27'd0, 5'b11001});
    put_bit(1'b1, 0);
    check("break_exit_busy", {31'd0, busy1}, 32'd0);
    exp_q1.push_back(5'b00001);
    send_frame(5'b00001, 1'b1, 1'b1, 1'b1, 0);
    put_bit(1'b1, 0);
    @(negedge CLK);
    check("break_recover_valid", 32'(v1 - sv), 32'd1);
    check("break_recover_dout", {27'd0, dout1}, {27'd0, 5'b00001});

    // Back-to-back frames with no idle strobe between them
    exp_q1.push_back(5'b11111);
    exp_q1.push_back(5'b00000);
    send_frame(5'b11111, 1'b1, 1'b1, 1'b1, 0);
    send_frame(5'b00000, 1'b1, 1'b0, 1'b1, 0);
    put_bit(1'b1, 0);
    @(negedge CLK);
    check("b2b_spacing", 32'(last_v_cyc - prev_v_cyc), 32'd8);
    check("b2b_dout", {27'd0, dout1}, 32'd0);
    check("b2b_ds", {27'd0, ds_reg}, 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);

    // Sparse strobe on the no-parity instance
    mon1_en = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    mon0_en = 1'b1;
    sv = v0;
    exp_q0.push_back(5'b10101);
    send_frame(5'b10101, 1'b0, 1'b0, 1'b1, 2);
    put_bit(1'b1, 2);
    @(negedge CLK);
    check("sparse_valid", 32'(v0 - sv), 32'd1);
    check("sparse_dout", {27'd0, dout0}, {27'd0, 5'b10101});
    check("sparse_busy", {31'd0, busy0}, 32'd0);
    exp_q0.push_back(5'b01100);
    send_frame(5'b01100, 1'b0, 1'b0, 1'b1, 1);
    put_bit(1'b1, 1);
    @(negedge CLK);
    check("sparse2_valid", 32'(v0 - sv), 32'd2);
    check("noparity_perr", 32'(p0), 32'd0);
    check("noparity_ferr", 32'(f0), 32'd0);
    check("q0_empty", 32'(exp_q0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
